mbus_mem_ctl: RTL and testbench

- Single-bank MBUS memory controller on the memory side of the KL10 MBUS.
- Consumes the MBOX request/data signals that the top level maps onto the memory modport: start, rd/wr request, quadword word mask, PMA 14:35, and write data.
- Produces acknowledge, read data and data-valid strobes back to the MBOX.
- Models MB20-style quadword transfers with configurable access timing, so the cache/MBOX path can be exercised against realistic handshakes.

---
 rtl/mbus_mem_pkg.sv | 26 ++
 rtl/mbus_mem_if.sv | 37 +++
 rtl/mbus_wordseq.sv | 56 +++++
 rtl/mbus_mem_ctl.sv | 225 ++++++++++++++++++++++
 tb/tb_mbus_mem_ctl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mbus_mem_pkg.sv
// Shared types and helpers for the MBUS memory controller.
// Optional build macro: MBUS_MEM_PARITY_EN (adds read/address/write parity).
package mbus_mem_pkg;

  localparam int unsigned WORD_W = 36;
  localparam int unsigned PMA_W  = 22;
  localparam int unsigned DLY_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK_WAIT,
    ST_RD_XFER,
    ST_WR_XFER,
    ST_DONE
  } tMemState;

  // KL10 bit n of a word (and PMA bit n) lives at vector index 35-n.
  typedef logic [WORD_W-1:0] tWord;
  typedef logic [PMA_W-1:0]  tPMA;

  // Odd parity bit: the 36 data bits plus this bit carry an odd count of ones.
  function automatic logic oddpar36(input tWord w);
    return ~^w;
  endfunction

endpackage

// File: rtl/mbus_mem_if.sv
// MBOX <-> memory signal bundle; master is the MBOX side, slave the memory.
interface mbus_mem_if;
  import mbus_mem_pkg::*;

  logic       start_a;
  logic       start_b;
  logic       rd_rq;
  logic       wr_rq;
  logic [3:0] rq;
  tPMA        adr;
  logic       adr_par;
  logic       mem_reset;
  tWord       d_out;
  logic       par_out;
  logic       out_valid_a;
  logic       out_valid_b;
  tWord       d_in;
  logic       par_in;
  logic       ackn_a;
  logic       ackn_b;
  logic       in_valid_a;
  logic       in_valid_b;
  logic       busy;

  modport master (
    output start_a, start_b, rd_rq, wr_rq, rq, adr, adr_par, mem_reset,
           d_out, par_out, out_valid_a, out_valid_b,
    input  d_in, par_in, ackn_a, ackn_b, in_valid_a, in_valid_b, busy
  );

  modport slave (
    input  start_a, start_b, rd_rq, wr_rq, rq, adr, adr_par, mem_reset,
           d_out, par_out, out_valid_a, out_valid_b,
    output d_in, par_in, ackn_a, ackn_b, in_valid_a, in_valid_b, busy
  );

endinterface

// File: rtl/mbus_wordseq.sv
// Quadword word sequencer: wrap pointer plus remaining-word mask.
// word_c_o/last_c_o are combinational decodes of the registered state.
module mbus_wordseq
  import mbus_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_l,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic       adv_i,
  input  logic [1:0] w0_i,
  input  logic [3:0] mask_i,
  output logic [1:0] word_c_o,
  output logic       last_c_o
);

  logic [1:0] w_q, w_d;
  logic [3:0] rem_q, rem_d;

  // First remaining word at or after the pointer, wrapping within the quadword
  always_comb begin
    word_c_o = w_q;
    for (int i = 3; i >= 0; i--) begin
      if (rem_q[2'(w_q + 2'(i))]) word_c_o = 2'(w_q + 2'(i));
    end
    last_c_o = ((rem_q & ~(4'b0001 << word_c_o)) == 4'b0000);
  end

  // Load wins over advance so a read-pause-write reload is not lost
  always_comb begin
    w_d   = w_q;
    rem_d = rem_q;
    if (clr_i) begin
      w_d   = 2'b00;
      rem_d = 4'b0000;
    end else if (load_i) begin
      w_d   = w0_i;
      rem_d = mask_i;
    end else if (adv_i) begin
      w_d   = 2'(word_c_o + 2'd1);
      rem_d = rem_q & ~(4'b0001 << word_c_o);
    end
  end

  // Pointer and mask registers
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      w_q   <= 2'b00;
      rem_q <= 4'b0000;
    end else begin
      w_q   <= w_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/mbus_mem_ctl.sv
// Single-bank MB20-style MBUS memory controller with quadword transfers.
// Optional build macro: MBUS_MEM_PARITY_EN (read parity, address parity
// rejection, sticky write-parity flag).
module mbus_mem_ctl
  import mbus_mem_pkg::*;
#(
  parameter int unsigned MEMSIZE  = 512*1024,
  parameter int unsigned ACK_DLY  = 2,
  parameter int unsigned WORD_DLY = 1
) (
  input  logic        clk,
  input  logic        reset_l,
  mbus_mem_if.slave   bus
);

  localparam int unsigned AW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [DLY_W-1:0] ACK_RELOAD  = DLY_W'(ACK_DLY - 1);
  localparam logic [DLY_W-1:0] WORD_RELOAD = DLY_W'(WORD_DLY - 1);

  tWord mem [MEMSIZE];

  tMemState         state_q, state_d;
  logic             port_q, port_d;        // 0 = port A, 1 = port B
  tPMA              adr_q, adr_d;
  logic [3:0]       rq_q, rq_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             ackn_a_q, ackn_a_d, ackn_b_q, ackn_b_d;
  logic             ival_a_q, ival_a_d, ival_b_q, ival_b_d;
  tWord             d_in_q, d_in_d;
  logic             par_in_q, par_in_d;
  logic             busy_q, busy_d;

  logic          nxm_c, adr_ok_c, out_valid_c, rd_par_c;
  logic          seq_load_c, seq_adv_c, seq_clr_c, seq_last_c, mem_we_c;
  logic [1:0]    seq_w0_c, seq_word_c;
  logic [3:0]    seq_mask_c;
  logic [AW-1:0] mem_addr_c;
  tWord          rd_word_c;

  assign nxm_c       = 32'({bus.adr[21:2], 2'b00}) >= 32'(MEMSIZE);
  assign out_valid_c = port_q ? bus.out_valid_b : bus.out_valid_a;
  assign seq_w0_c    = (state_q == ST_IDLE) ? bus.adr[1:0] : adr_q[1:0];
  assign seq_mask_c  = (state_q == ST_IDLE) ? bus.rq : rq_q;
  assign mem_addr_c  = AW'({adr_q[21:2], seq_word_c});
  assign rd_word_c   = mem[mem_addr_c];

`ifdef MBUS_MEM_PARITY_EN
  logic par_err_q;
  assign adr_ok_c = ((^{bus.adr, bus.adr_par}) == 1'b1);
  assign rd_par_c = oddpar36(rd_word_c);

  // Sticky write-parity error; the bad word is still stored
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)                                             par_err_q <= 1'b0;
    else if (mem_we_c && ((^{bus.d_out, bus.par_out}) == 1'b0)) par_err_q <= 1'b1;
  end
`else
  logic unused_par;
  assign adr_ok_c   = 1'b1;
  assign rd_par_c   = 1'b0;
  assign unused_par = ^{bus.adr_par, bus.par_out};
`endif

  mbus_wordseq u_seq (
    .clk      (clk),
    .reset_l  (reset_l),
    .clr_i    (seq_clr_c),
    .load_i   (seq_load_c),
    .adv_i    (seq_adv_c),
    .w0_i     (seq_w0_c),
    .mask_i   (seq_mask_c),
    .word_c_o (seq_word_c),
    .last_c_o (seq_last_c)
  );

  // Next-state and output decode; mem_reset overrides everything last
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    adr_d      = adr_q;
    rq_d       = rq_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    dly_d      = dly_q;
    ackn_a_d   = 1'b0;
    ackn_b_d   = 1'b0;
    ival_a_d   = 1'b0;
    ival_b_d   = 1'b0;
    d_in_d     = d_in_q;
    par_in_d   = par_in_q;
    seq_load_c = 1'b0;
    seq_adv_c  = 1'b0;
    seq_clr_c  = 1'b0;
    mem_we_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((bus.start_a || bus.start_b) && !nxm_c && adr_ok_c) begin
          port_d     = ~bus.start_a;
          adr_d      = bus.adr;
          rq_d       = bus.rq;
          rd_d       = bus.rd_rq;
          wr_d       = bus.wr_rq;
          dly_d      = ACK_RELOAD;
          seq_load_c = 1'b1;
          state_d    = ST_ACK_WAIT;
        end
      end
      ST_ACK_WAIT: begin
        if (dly_q == '0) begin
          ackn_a_d = ~port_q;
          ackn_b_d = port_q;
          dly_d    = WORD_RELOAD;
          if (rq_q == 4'b0000) state_d = ST_DONE;
          else if (rd_q)       state_d = ST_RD_XFER;
          else if (wr_q)       state_d = ST_WR_XFER;
          else                 state_d = ST_DONE;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      ST_RD_XFER: begin
        if (dly_q == '0) begin
          d_in_d    = rd_word_c;
          par_in_d  = rd_par_c;
          ival_a_d  = ~port_q;
          ival_b_d  = port_q;
          seq_adv_c = 1'b1;
          dly_d     = WORD_RELOAD;
          if (seq_last_c) begin
            if (wr_q) begin
              seq_load_c = 1'b1;
              state_d    = ST_WR_XFER;
            end else begin
              state_d = ST_DONE;
            end
          end
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      ST_WR_XFER: begin
        if (out_valid_c) begin
          mem_we_c  = 1'b1;
          seq_adv_c = 1'b1;
          if (seq_last_c) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.mem_reset) begin
      state_d    = ST_IDLE;
      port_d     = 1'b0;
      adr_d      = '0;
      rq_d       = 4'b0000;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      dly_d      = '0;
      ackn_a_d   = 1'b0;
      ackn_b_d   = 1'b0;
      ival_a_d   = 1'b0;
      ival_b_d   = 1'b0;
      d_in_d     = '0;
      par_in_d   = 1'b0;
      seq_load_c = 1'b0;
      seq_adv_c  = 1'b0;
      seq_clr_c  = 1'b1;
      mem_we_c   = 1'b0;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  // Control and output registers
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= ST_IDLE;
      port_q   <= 1'b0;
      adr_q    <= '0;
      rq_q     <= 4'b0000;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      dly_q    <= '0;
      ackn_a_q <= 1'b0;
      ackn_b_q <= 1'b0;
      ival_a_q <= 1'b0;
      ival_b_q <= 1'b0;
      d_in_q   <= '0;
      par_in_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      adr_q    <= adr_d;
      rq_q     <= rq_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      dly_q    <= dly_d;
      ackn_a_q <= ackn_a_d;
      ackn_b_q <= ackn_b_d;
      ival_a_q <= ival_a_d;
      ival_b_q <= ival_b_d;
      d_in_q   <= d_in_d;
      par_in_q <= par_in_d;
      busy_q   <= busy_d;
    end
  end

  // Storage write port; contents survive both resets
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_addr_c] <= bus.d_out;
  end

  assign bus.ackn_a     = ackn_a_q;
  assign bus.ackn_b     = ackn_b_q;
  assign bus.in_valid_a = ival_a_q;
  assign bus.in_valid_b = ival_b_q;
  assign bus.d_in       = d_in_q;
  assign bus.par_in     = par_in_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mbus_mem_ctl.sv
// Directed bench for mbus_mem_ctl: quadword reads/writes, wrap and mask,
// non-existent memory, read-pause-write, async reset and mem_reset aborts.
module tb_mbus_mem_ctl;
  import mbus_mem_pkg::*;

  localparam int unsigned MEMSIZE  = 512*1024;
  localparam int          ACK_DLY  = 2;
  localparam int          WORD_DLY = 1;

  typedef logic [3:0][35:0] quad_t;

  logic clk     = 1'b0;
  logic reset_l = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  mbus_mem_if bus ();

  mbus_mem_ctl #(
    .MEMSIZE  (MEMSIZE),
    .ACK_DLY  (ACK_DLY),
    .WORD_DLY (WORD_DLY)
  ) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic quad_t q4(input logic [35:0] a, input logic [35:0] b,
                               input logic [35:0] c, input logic [35:0] d);
    quad_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic logic exp_par(input logic [35:0] w);
`ifdef MBUS_MEM_PARITY_EN
    return ~^w;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_start(input logic port, input logic v);
    if (port) bus.start_b = v; else bus.start_a = v;
  endtask

  task automatic set_ov(input logic port, input logic v);
    if (port) bus.out_valid_b = v; else bus.out_valid_a = v;
  endtask

  function automatic logic ack_of(input logic port);
    return port ? bus.ackn_b : bus.ackn_a;
  endfunction

  function automatic logic ival_of(input logic port);
    return port ? bus.in_valid_b : bus.in_valid_a;
  endfunction

  // One full transaction; exp/wdat are listed in visiting order
  task automatic xfer(input string tag, input logic port, input logic rd, input logic wr,
                      input logic [21:0] adr, input logic [3:0] rq,
                      input int nrd, input quad_t exp, input int nwr, input quad_t wdat,
                      input logic other);
    int lat, k, t, first_t, last_t, wrong;
    lat = 0; k = 0; t = 0; first_t = 0; last_t = 0; wrong = 0;
    bus.rd_rq = rd; bus.wr_rq = wr; bus.rq = rq; bus.adr = adr; bus.adr_par = ~^adr;
    set_start(port, 1'b1);
    if (other) set_start(!port, 1'b1);
    tick();
    set_start(port, 1'b0);
    check_eq($sformatf("%s_busy_acc", tag), bus.busy, 1);
    do begin
      tick();
      lat++;
      if (ack_of(!port)) wrong++;
    end while (!ack_of(port) && lat < 20);
    check_eq($sformatf("%s_ack_lat", tag), lat, ACK_DLY);
    if (!ack_of(port)) begin
      set_start(!port, 1'b0);
      return;
    end
    while (k < nrd && t < 40) begin
      tick();
      t++;
      if (ack_of(port) || ack_of(!port) || ival_of(!port)) wrong++;
      if (ival_of(port)) begin
        check_eq($sformatf("%s_rd%0d", tag, k), bus.d_in, exp[k]);
        check_eq($sformatf("%s_par%0d", tag, k), bus.par_in, exp_par(exp[k]));
        if (k == 0) first_t = t;
        last_t = t;
        k++;
      end
    end
    if (nrd > 0) begin
      check_eq($sformatf("%s_rd_cnt", tag), k, nrd);
      check_eq($sformatf("%s_rd_span", tag), last_t - first_t, (nrd - 1) * WORD_DLY);
    end
    if (nwr > 0) begin
      // junk strobe on the other port must not be taken as a write
      set_ov(!port, 1'b1);
      bus.d_out = 36'hDEAD_BEEF_0;
      bus.par_out = ~^bus.d_out;
      tick();
      set_ov(!port, 1'b0);
      for (int i = 0; i < nwr; i++) begin
        set_ov(port, 1'b1);
        bus.d_out = wdat[i];
        bus.par_out = ~^wdat[i];
        tick();
        if (bus.ackn_a || bus.ackn_b || bus.in_valid_a || bus.in_valid_b) wrong++;
      end
      set_ov(port, 1'b0);
    end
    if (other) set_start(!port, 1'b0);
    check_eq($sformatf("%s_stray", tag), wrong, 0);
    check_eq($sformatf("%s_busy_done", tag), bus.busy, 1);
    tick();
    check_eq($sformatf("%s_busy_idle", tag), bus.busy, 0);
  endtask

  initial begin
    int t, acks, busys, strays;
    bus.start_a = 0; bus.start_b = 0; bus.rd_rq = 0; bus.wr_rq = 0; bus.rq = 0;
    bus.adr = 0; bus.adr_par = 1; bus.mem_reset = 0; bus.d_out = 0; bus.par_out = 1;
    bus.out_valid_a = 0; bus.out_valid_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", {bus.ackn_a, bus.ackn_b, bus.in_valid_a, bus.in_valid_b,
                            bus.busy, bus.par_in, bus.d_in}, 0);
    reset_l = 1'b1;
    tick();

    // Preload quadwords 0, 4, 8 and 16 through the bus
    xfer("pre0",  1'b0, 1'b0, 1'b1, 22'd0,  4'b1111, 0, '0, 4, q4(36'd1, 36'd2, 36'd3, 36'd4), 1'b0);
    xfer("pre4",  1'b1, 1'b0, 1'b1, 22'd4,  4'b1111, 0, '0, 4, q4(36'h40, 36'h41, 36'h42, 36'h43), 1'b0);
    xfer("pre8",  1'b0, 1'b0, 1'b1, 22'd8,  4'b1111, 0, '0, 4, q4(36'h8_0000_0008, 36'd9, 36'd10, 36'd11), 1'b0);
    xfer("pre16", 1'b1, 1'b0, 1'b1, 22'd16, 4'b1111, 0, '0, 4, q4(36'h160, 36'h161, 36'h162, 36'h163), 1'b0);

    // Aligned read of quadword 0
    xfer("aligned", 1'b0, 1'b1, 1'b0, 22'd0, 4'b1111, 4, q4(36'd1, 36'd2, 36'd3, 36'd4), 0, '0, 1'b0);

    // Port B, start word 2, words {0,2,3}: order 2,3,0
    xfer("wrap", 1'b1, 1'b1, 1'b0, 22'd6, 4'b1101, 3, q4(36'h42, 36'h43, 36'h40, 36'h0), 0, '0, 1'b0);

    // Masked write of words 16 and 18, then read the whole quadword back
    xfer("wr16", 1'b0, 1'b0, 1'b1, 22'd16, 4'b0101, 0, '0, 2, q4(36'd777, 36'd555, 36'd0, 36'd0), 1'b0);
    xfer("rb16", 1'b0, 1'b1, 1'b0, 22'd16, 4'b1111, 4, q4(36'd777, 36'h161, 36'd555, 36'h163), 0, '0, 1'b0);

    // Non-existent memory: start ignored, no ack, never busy
    bus.adr = 22'(MEMSIZE); bus.adr_par = ~^bus.adr; bus.rd_rq = 1; bus.wr_rq = 0; bus.rq = 4'b1111;
    bus.start_a = 1'b1;
    tick();
    bus.start_a = 1'b0;
    acks = 0; busys = 0;
    repeat (20) begin
      if (bus.ackn_a || bus.ackn_b) acks++;
      if (bus.busy) busys++;
      tick();
    end
    check_eq("nxm_ack", acks, 0);
    check_eq("nxm_busy", busys, 0);
    xfer("after_nxm", 1'b1, 1'b1, 1'b0, 22'd0, 4'b0001, 1, q4(36'd1, 36'd0, 36'd0, 36'd0), 0, '0, 1'b0);

    // Last word of memory is addressable
    xfer("top_wr", 1'b0, 1'b0, 1'b1, 22'(MEMSIZE - 1), 4'b1000, 0, '0, 1, q4(36'h5A5, 36'd0, 36'd0, 36'd0), 1'b0);
    xfer("top_rd", 1'b1, 1'b1, 1'b0, 22'(MEMSIZE - 1), 4'b1000, 1, q4(36'h5A5, 36'd0, 36'd0, 36'd0), 0, '0, 1'b0);

    // Read-pause-write with both starts raised: A wins, B held during busy is ignored
    xfer("rpw", 1'b0, 1'b1, 1'b1, 22'd8, 4'b0001, 1, q4(36'h8_0000_0008, 36'd0, 36'd0, 36'd0),
         1, q4(36'hF_0F0F_0F0F, 36'd0, 36'd0, 36'd0), 1'b1);
    xfer("rpw_rb", 1'b1, 1'b1, 1'b0, 22'd8, 4'b0001, 1, q4(36'hF_0F0F_0F0F, 36'd0, 36'd0, 36'd0), 0, '0, 1'b0);

    // Async reset after the first data word of a read
    bus.adr = 22'd0; bus.adr_par = ~^bus.adr; bus.rd_rq = 1; bus.wr_rq = 0; bus.rq = 4'b1111;
    bus.start_a = 1'b1;
    tick();
    bus.start_a = 1'b0;
    t = 0;
    while (!bus.in_valid_a && t < 20) begin
      tick();
      t++;
    end
    check_eq("rst_word0", bus.d_in, 36'd1);
    #2 reset_l = 1'b0;
    #1;
    check_eq("rst_mid_outs", {bus.ackn_a, bus.ackn_b, bus.in_valid_a, bus.in_valid_b,
                              bus.busy, bus.par_in, bus.d_in}, 0);
    #3 reset_l = 1'b1;
    tick();
    check_eq("rst_idle", bus.busy, 0);
    xfer("after_rst", 1'b0, 1'b1, 1'b0, 22'd0, 4'b1111, 4, q4(36'd1, 36'd2, 36'd3, 36'd4), 0, '0, 1'b0);

    // mem_reset right after ack aborts the read silently
    bus.adr = 22'd0; bus.adr_par = ~^bus.adr; bus.rd_rq = 1; bus.wr_rq = 0; bus.rq = 4'b1111;
    bus.start_b = 1'b1;
    tick();
    bus.start_b = 1'b0;
    t = 0;
    while (!bus.ackn_b && t < 20) begin
      tick();
      t++;
    end
    bus.mem_reset = 1'b1;
    tick();
    bus.mem_reset = 1'b0;
    check_eq("mrst_outs", {bus.ackn_a, bus.ackn_b, bus.in_valid_a, bus.in_valid_b,
                           bus.busy, bus.par_in, bus.d_in}, 0);
    strays = 0;
    repeat (10) begin
      tick();
      if (bus.ackn_a || bus.ackn_b || bus.in_valid_a || bus.in_valid_b || bus.busy) strays++;
    end
    check_eq("mrst_quiet", strays, 0);
    xfer("after_mrst", 1'b1, 1'b1, 1'b0, 22'd2, 4'b0100, 1, q4(36'd3, 36'd0, 36'd0, 36'd0), 0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
